// File: rtl/ascensor_pkg.sv
// ascensor_pkg: button index map, button count and per-floor request masks
package ascensor_pkg;
    localparam int N_BOTONES = 13;
    localparam int N_PISOS   = 5;
    localparam int BTN_PISO1  = 0;
    localparam int BTN_PISO2  = 1;
    localparam int BTN_PISO3  = 2;
    localparam int BTN_PISO4  = 3;
    localparam int BTN_PISO5  = 4;
    localparam int BTN_SUBIR1 = 5;
    localparam int BTN_SUBIR2 = 6;
    localparam int BTN_BAJAR2 = 7;
    localparam int BTN_SUBIR3 = 8;
    localparam int BTN_BAJAR3 = 9;
    localparam int BTN_SUBIR4 = 10;
    localparam int BTN_BAJAR4 = 11;
    localparam int BTN_BAJAR5 = 12;
    // Entry k selects the cabin and hall buttons that belong to floor k+1
    localparam logic [N_PISOS-1:0][N_BOTONES-1:0] MASK_PISO = {
        13'h1010,
        13'h0C08,
        13'h0304,
        13'h00C2,
        13'h0021
    };
endpackage

// File: rtl/antirrebote.sv
// antirrebote: one-bit synchronizer, tick-sampled debouncer and rising-edge pulse
//   clk, reset : clock, async active-high reset
//   tick       : debounce sample strobe shared by all bits
//   raw        : asynchronous button input
//   level      : debounced level
//   pulse      : one-cycle pulse per accepted 0->1 change
module antirrebote #(
    parameter int DB_SAMPLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int CW = $clog2(DB_SAMPLES + 1);

    logic          meta;
    logic          sync;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            meta    <= raw;
            sync    <= meta;
            level_d <= level;
            pulse   <= level & ~level_d;
            // Any sample agreeing with the current level restarts the count
            if (tick) begin
                if (sync == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DB_SAMPLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/botones_llamada.sv
// botones_llamada: debounces the 13 call buttons and keeps sticky service requests
//   clk, reset : clock, async active-high reset
//   btn_raw    : raw asynchronous buttons
//   clear      : per-bit request clear from the controller
//   btn_level  : debounced levels
//   btn_pulse  : one-cycle press pulses
//   req        : sticky request latches
//   req_piso   : per-floor OR of req
//   any_req    : OR of all requests
module botones_llamada
    import ascensor_pkg::*;
#(
    parameter int TICK_DIV   = 100_000,
    parameter int DB_SAMPLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BOTONES-1:0] btn_raw,
    input  logic [N_BOTONES-1:0] clear,
    output logic [N_BOTONES-1:0] btn_level,
    output logic [N_BOTONES-1:0] btn_pulse,
    output logic [N_BOTONES-1:0] req,
    output logic [N_PISOS-1:0]   req_piso,
    output logic                 any_req
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            req  <= '0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            // A press arriving with a clear wins so it is never lost
            req  <= (req & ~clear) | btn_pulse;
        end
    end

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_btn
        antirrebote #(.DB_SAMPLES(DB_SAMPLES)) u_ar (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    for (genvar k = 0; k < N_PISOS; k++) begin : g_piso
        assign req_piso[k] = |(req & MASK_PISO[k]);
    end

    assign any_req = |req;
endmodule

// File: tb/tb_botones_llamada.sv
// tb_botones_llamada: vector table plus corner sequences with a pulse scoreboard
module tb_botones_llamada;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] btn_raw = '0;
    logic [12:0] clear = '0;
    logic [12:0] btn_level;
    logic [12:0] btn_pulse;
    logic [12:0] req;
    logic [4:0]  req_piso;
    logic        any_req;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [12:0] press;
        logic [4:0]  piso;
    } vec_t;

    vec_t        tbl[8];
    logic [12:0] exp_q[$];

    botones_llamada #(.TICK_DIV(4), .DB_SAMPLES(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .clear     (clear),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .req       (req),
        .req_piso  (req_piso),
        .any_req   (any_req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_level(input logic [12:0] m, input logic [12:0] v, output int n);
        n = 0;
        while ((btn_level & m) != v && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("level_reached", btn_level & m, v);
    endtask

    // Every nonzero pulse vector must match the next expected press, once
    always @(negedge clk) begin
        if (btn_pulse != '0) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", btn_pulse, 0);
            else chk("pulse", btn_pulse, exp_q.pop_front());
        end
    end

    task automatic release_and_clear();
        int n;
        btn_raw = '0;
        wait_level(13'h1fff, 13'h0000, n);
        cyc(3);
        clear = 13'h1fff;
        cyc(1);
        clear = '0;
        chk("cleared_req", req, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{13'h0004, 5'b00100};
        tbl[1] = '{13'h0810, 5'b11000};
        tbl[2] = '{13'h0021, 5'b00001};
        tbl[3] = '{13'h00C0, 5'b00010};
        tbl[4] = '{13'h0300, 5'b00100};
        tbl[5] = '{13'h1000, 5'b10000};
        tbl[6] = '{13'h0400, 5'b01000};
        tbl[7] = '{13'h1fff, 5'b11111};

        cyc(3);
        chk("rst_level", btn_level, 0);
        chk("rst_pulse", btn_pulse, 0);
        chk("rst_req", req, 0);
        chk("rst_piso", req_piso, 0);
        chk("rst_any", any_req, 0);
        reset = 1'b0;
        cyc(2);

        for (int i = 0; i < 8; i++) begin
            btn_raw = tbl[i].press;
            exp_q.push_back(tbl[i].press);
            wait_level(tbl[i].press, tbl[i].press, n);
            if (i == 0) chk("press_latency_in_9_18", (n >= 9 && n <= 18), 1);
            cyc(2);
            chk("vec_req", req, tbl[i].press);
            chk("vec_piso", req_piso, tbl[i].piso);
            chk("vec_any", any_req, 1);
            release_and_clear();
            chk("vec_piso_cleared", req_piso, 0);
            chk("vec_any_cleared", any_req, 0);
        end

        // Bounce on bajar2: 5-cycle segments never span 3 ticks
        for (int i = 0; i < 8; i++) begin
            btn_raw[7] = ~btn_raw[7];
            cyc(5);
        end
        chk("bounce_level", btn_level, 0);
        chk("bounce_req", req, 0);
        btn_raw[7] = 1'b1;
        exp_q.push_back(13'h0080);
        wait_level(13'h0080, 13'h0080, n);
        cyc(2);
        chk("bounce_piso", req_piso, 5'b00010);
        release_and_clear();

        // Clear while held, then a fresh press sets again
        btn_raw = 13'h0001;
        exp_q.push_back(13'h0001);
        wait_level(13'h0001, 13'h0001, n);
        cyc(2);
        chk("held_req_set", req[0], 1);
        clear = 13'h0001;
        cyc(1);
        clear = '0;
        chk("held_req_cleared", req[0], 0);
        cyc(20);
        chk("held_req_stays_0", req, 0);
        chk("held_level_still_1", btn_level[0], 1);
        btn_raw = '0;
        wait_level(13'h0001, 13'h0000, n);
        btn_raw = 13'h0001;
        exp_q.push_back(13'h0001);
        wait_level(13'h0001, 13'h0001, n);
        cyc(2);
        chk("repress_req", req[0], 1);
        release_and_clear();

        // Clear in the same cycle as the pulse: set wins
        btn_raw = 13'h1000;
        exp_q.push_back(13'h1000);
        wait_level(13'h1000, 13'h1000, n);
        cyc(1);
        chk("collision_pulse", btn_pulse[12], 1);
        clear = 13'h1000;
        cyc(1);
        chk("collision_req_set", req[12], 1);
        cyc(1);
        clear = '0;
        chk("collision_later_clear", req[12], 0);
        release_and_clear();

        // Phase-align the tick with a reset, then check exact latency
        reset = 1'b1;
        btn_raw = 13'h0002;
        cyc(1);
        reset = 1'b0;
        exp_q.push_back(13'h0002);
        cyc(11);
        chk("exact_before", btn_level, 0);
        cyc(1);
        chk("exact_level", btn_level, 13'h0002);
        cyc(2);
        chk("exact_req", req, 13'h0002);
        // Bit 3 gets two ticks of debounce, then reset lands mid-cycle
        btn_raw = 13'h000A;
        cyc(11);
        chk("mid_debounce_level", btn_level, 13'h0002);
        #2 reset = 1'b1;
        #1;
        chk("async_level", btn_level, 0);
        chk("async_req", req, 0);
        chk("async_piso", req_piso, 0);
        chk("async_any", any_req, 0);
        chk("async_pulse", btn_pulse, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(13'h000A);
        cyc(11);
        chk("restart_before", btn_level, 0);
        cyc(1);
        chk("restart_level", btn_level, 13'h000A);
        cyc(2);
        chk("restart_req", req, 13'h000A);
        chk("restart_piso", req_piso, 5'b01010);
        release_and_clear();

        cyc(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
